// File: rtl/ddr_cmd_if.sv
// ddr_cmd_if: DDR4 command/address pins in, decoded command strobes and addresses out
interface ddr_cmd_if #(
   parameter int BGWIDTH    = 1,
   parameter int BAWIDTH    = 1,
   parameter int ADDRWIDTH  = 17,
   parameter int CADDRWIDTH = 10
);
   logic                  cke, cs_n, act_n, ras_n, cas_n, we_n;
   logic [BGWIDTH-1:0]    bg_in;
   logic [BAWIDTH-1:0]    ba_in;
   logic [ADDRWIDTH-4:0]  addr;
   logic                  ACT, PR, PRA, RD, RDA, WR, WRA, REF, SRF, PD, PDX, MRW, CKEH, CKEL;
   logic                  BST, CFG, DPD, DPDX, MRR;
   logic [BGWIDTH:0]      bg;
   logic [BAWIDTH:0]      ba;
   logic [ADDRWIDTH-1:0]  row;
   logic [CADDRWIDTH-1:0] column;
   logic                  err;
   modport master (
      output cke, cs_n, act_n, ras_n, cas_n, we_n, bg_in, ba_in, addr,
      input  ACT, PR, PRA, RD, RDA, WR, WRA, REF, SRF, PD, PDX, MRW, CKEH, CKEL,
      input  BST, CFG, DPD, DPDX, MRR, bg, ba, row, column, err
   );
   modport slave (
      input  cke, cs_n, act_n, ras_n, cas_n, we_n, bg_in, ba_in, addr,
      output ACT, PR, PRA, RD, RDA, WR, WRA, REF, SRF, PD, PDX, MRW, CKEH, CKEL,
      output BST, CFG, DPD, DPDX, MRR, bg, ba, row, column, err
   );
endinterface

// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: DDR4 pin decoder with bank/tRCD legality checks and power-down/self-refresh tracking
module ddr_cmd_decoder #(
   parameter int ADDRWIDTH     = 17,
   parameter int BANKGROUPS    = 2,
   parameter int BANKSPERGROUP = 2,
   parameter int COLS          = 1024,
   parameter int TRCD          = 4
) (
   input logic clk,
   input logic rst,
   ddr_cmd_if.slave bus
);
   localparam int BGWIDTH    = $clog2(BANKGROUPS);
   localparam int BAWIDTH    = $clog2(BANKSPERGROUP);
   localparam int CADDRWIDTH = $clog2(COLS);
   localparam int BI         = BGWIDTH + BAWIDTH;
   localparam int NB         = 1 << BI;
   typedef enum logic [1:0] {ACTIVE, PDOWN, SREF} pwr_e;
   pwr_e                  state_q, state_d;
   logic                  cke_q;
   logic [NB-1:0]         open_q;
   logic [3:0]            cnt_q [NB];
   logic [13:0]           strb_q, strb_d;
   logic                  err_q, err_d;
   logic [BGWIDTH:0]      bg_q;
   logic [BAWIDTH:0]      ba_q;
   logic [ADDRWIDTH-1:0]  row_q;
   logic [CADDRWIDTH-1:0] col_q;
   logic [BI-1:0]         b;
   logic [2:0]            rcw;
   logic                  a10, dec, fall, rise, any_open, issued, bad, to_sref;
   logic                  c_act, c_mrw, c_ref, c_pre, c_wr, c_rd;
   logic                  acc_act, acc_pra, acc_clr, ld;
   assign b        = {bus.bg_in, bus.ba_in};
   assign rcw      = {bus.ras_n, bus.cas_n, bus.we_n};
   assign a10      = bus.addr[10];
   assign dec      = state_q == ACTIVE && !bus.cs_n;
   assign fall     = cke_q && !bus.cke;
   assign rise     = !cke_q && bus.cke;
   assign any_open = |open_q;
   assign c_act    = dec && !bus.act_n;
   assign c_mrw    = dec && bus.act_n && rcw == 3'b000;
   assign c_ref    = dec && bus.act_n && rcw == 3'b001;
   assign c_pre    = dec && bus.act_n && rcw == 3'b010;
   assign c_wr     = dec && bus.act_n && rcw == 3'b100;
   assign c_rd     = dec && bus.act_n && rcw == 3'b101;
   assign issued   = dec && !(bus.act_n && rcw == 3'b111);
   assign bad      = (c_act && open_q[b]) || ((c_rd || c_wr) && (!open_q[b] || cnt_q[b] != 4'd0)) || ((c_ref || c_mrw) && any_open);
   assign to_sref  = c_ref && !any_open;
   // strobe bit order: ACT PR PRA RD RDA WR WRA REF SRF PD PDX MRW CKEH CKEL
   assign acc_act  = strb_d[13];
   assign acc_pra  = strb_d[11];
   assign acc_clr  = strb_d[12] || strb_d[9] || strb_d[7];
   assign ld       = |{strb_d[13:6], strb_d[2]};
   // Power-state next state plus command strobe/err selection; illegal commands yield no strobe
   always_comb begin
      state_d = state_q;
      strb_d  = '0;
      err_d   = 1'b0;
      case (state_q)
         ACTIVE: begin
            if (fall) begin
               state_d = to_sref ? SREF : PDOWN;
               strb_d  = to_sref ? 14'h0021 : 14'h0011;
               err_d   = !to_sref && issued;
            end else begin
               strb_d  = bad ? '0 : {c_act, c_pre && !a10, c_pre && a10, c_rd && !a10, c_rd && a10,
                                     c_wr && !a10, c_wr && a10, c_ref, 3'b000, c_mrw, 2'b00};
               err_d   = bad;
            end
         end
         PDOWN: if (rise) begin
            state_d = ACTIVE;
            strb_d  = 14'h000a;
         end
         SREF: if (rise) begin
            state_d = ACTIVE;
            strb_d  = 14'h0002;
         end
         default: state_d = ACTIVE;
      endcase
   end
   // Power state and registered cke used for edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= ACTIVE;
         cke_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cke_q   <= bus.cke;
      end
   // Per-bank open bit and saturating tRCD down-counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         open_q <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= 4'd0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (acc_act && b == BI'(i)) begin
               open_q[i] <= 1'b1;
               cnt_q[i]  <= 4'(TRCD - 1);
            end else if (acc_pra || (acc_clr && b == BI'(i))) begin
               open_q[i] <= 1'b0;
               cnt_q[i]  <= 4'd0;
            end else if (cnt_q[i] != 4'd0) begin
               cnt_q[i]  <= cnt_q[i] - 4'd1;
            end
         end
      end
   // Output strobes pulse for one cycle; address registers hold until the next accepted command
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         strb_q <= '0;
         err_q  <= 1'b0;
         bg_q   <= '0;
         ba_q   <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         strb_q <= strb_d;
         err_q  <= err_d;
         if (ld) begin
            bg_q  <= {1'b0, bus.bg_in};
            ba_q  <= {1'b0, bus.ba_in};
            row_q <= {bus.ras_n, bus.cas_n, bus.we_n, bus.addr};
            col_q <= bus.addr[CADDRWIDTH-1:0];
         end
      end
   assign {bus.ACT, bus.PR, bus.PRA, bus.RD, bus.RDA, bus.WR, bus.WRA,
           bus.REF, bus.SRF, bus.PD, bus.PDX, bus.MRW, bus.CKEH, bus.CKEL} = strb_q;
   assign bus.err    = err_q;
   assign bus.bg     = bg_q;
   assign bus.ba     = ba_q;
   assign bus.row    = row_q;
   assign bus.column = col_q;
   assign bus.BST    = 1'b0;
   assign bus.CFG    = 1'b0;
   assign bus.DPD    = 1'b0;
   assign bus.DPDX   = 1'b0;
   assign bus.MRR    = 1'b0;
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb_ddr_cmd_decoder: scoreboard bench for ddr_cmd_decoder with directed command vectors
module tb_ddr_cmd_decoder;
   localparam logic [13:0] S_ACT = 14'h2000, S_PR = 14'h1000, S_PRA = 14'h0800, S_RD = 14'h0400;
   localparam logic [13:0] S_RDA = 14'h0200, S_WR = 14'h0100, S_WRA = 14'h0080, S_REF = 14'h0040;
   localparam logic [13:0] S_SRF = 14'h0020, S_PD = 14'h0010, S_PDX = 14'h0008, S_MRW = 14'h0004;
   localparam logic [13:0] S_CKEH = 14'h0002, S_CKEL = 14'h0001;
   localparam logic [13:0] LD_MASK = S_ACT | S_PR | S_PRA | S_RD | S_RDA | S_WR | S_WRA | S_REF | S_MRW;
   typedef struct {
      string       nm;
      logic [13:0] s;
      logic        e;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [16:0] row;
      logic [9:0]  col;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        done = 1'b0;
   int          checks = 0;
   int          failures = 0;
   exp_t        q[$];
   exp_t        m_e;
   logic [13:0] m_s;
   logic [1:0]  x_bg, x_ba;
   logic [16:0] x_row;
   logic [9:0]  x_col;
   ddr_cmd_if #(.BGWIDTH(1), .BAWIDTH(1), .ADDRWIDTH(17), .CADDRWIDTH(10)) bus ();
   ddr_cmd_decoder #(.ADDRWIDTH(17), .BANKGROUPS(2), .BANKSPERGROUP(2), .COLS(1024), .TRCD(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // Drive one cycle of pins at the falling edge and queue the hand-computed response
   task automatic cmd(input string nm, input logic k, input logic cs, input logic an, input logic [2:0] rcw,
                      input logic [1:0] bank, input logic [13:0] a, input logic [13:0] es, input logic ee);
      exp_t e;
      @(negedge clk);
      bus.cke   = k;
      bus.cs_n  = cs;
      bus.act_n = an;
      {bus.ras_n, bus.cas_n, bus.we_n} = rcw;
      {bus.bg_in, bus.ba_in} = bank;
      bus.addr  = a;
      if ((es & LD_MASK) != 14'h0) begin
         x_bg  = {1'b0, bank[1]};
         x_ba  = {1'b0, bank[0]};
         x_row = {rcw, a};
         x_col = a[9:0];
      end
      e.nm = nm; e.s = es; e.e = ee; e.bg = x_bg; e.ba = x_ba; e.row = x_row; e.col = x_col;
      q.push_back(e);
   endtask
   task automatic desel(input string nm, input logic k, input logic [13:0] es);
      cmd(nm, k, 1'b1, 1'b1, 3'b111, 2'd0, 14'h0, es, 1'b0);
   endtask
   // Monitor: immediate all-zero check on reset, otherwise pop and compare after each rising edge
   initial begin : monitor
      while (!done) begin
         @(posedge clk or posedge rst);
         if (rst) begin
            #1;
            checks++;
            if ({bus.ACT, bus.PR, bus.PRA, bus.RD, bus.RDA, bus.WR, bus.WRA, bus.REF, bus.SRF, bus.PD, bus.PDX,
                 bus.MRW, bus.CKEH, bus.CKEL, bus.BST, bus.CFG, bus.DPD, bus.DPDX, bus.MRR, bus.err,
                 bus.bg, bus.ba, bus.row, bus.column} !== '0) begin
               failures++;
               $display("FAIL reset_state: outputs not all zero while rst high (row=%h col=%h err=%b)",
                        bus.row, bus.column, bus.err);
            end
         end else begin
            #2;
            m_s = {bus.ACT, bus.PR, bus.PRA, bus.RD, bus.RDA, bus.WR, bus.WRA,
                   bus.REF, bus.SRF, bus.PD, bus.PDX, bus.MRW, bus.CKEH, bus.CKEL};
            if (q.size() != 0) begin
               m_e = q.pop_front();
               checks++;
               if ({m_s, bus.err, bus.bg, bus.ba, bus.row, bus.column} !== {m_e.s, m_e.e, m_e.bg, m_e.ba, m_e.row, m_e.col}) begin
                  failures++;
                  $display("FAIL %s: got strb=%h err=%b bg=%h ba=%h row=%h col=%h, want strb=%h err=%b bg=%h ba=%h row=%h col=%h",
                           m_e.nm, m_s, bus.err, bus.bg, bus.ba, bus.row, bus.column,
                           m_e.s, m_e.e, m_e.bg, m_e.ba, m_e.row, m_e.col);
               end
            end else if (m_s !== 14'h0 || bus.err !== 1'b0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got strb=%h err=%b, want none", m_s, bus.err);
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected responses never observed, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   // Directed stimulus
   initial begin
      rst = 1'b1;
      bus.cke = 1'b1; bus.cs_n = 1'b1; bus.act_n = 1'b1;
      bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
      bus.bg_in = '0; bus.ba_in = '0; bus.addr = '0;
      x_bg = '0; x_ba = '0; x_row = '0; x_col = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmd("act_bg1_ba0",   1, 0, 0, 3'b000, 2'd2, 14'h0005, S_ACT, 0);
      cmd("act_bank0",     1, 0, 0, 3'b000, 2'd0, 14'h0012, S_ACT, 0);
      desel("nop_a", 1, 14'h0);
      desel("nop_b", 1, 14'h0);
      cmd("rd_k3_early",   1, 0, 1, 3'b101, 2'd0, 14'h0007, 14'h0, 1);
      cmd("rd_k4_ok",      1, 0, 1, 3'b101, 2'd0, 14'h0007, S_RD, 0);
      cmd("act_open_bank", 1, 0, 0, 3'b000, 2'd2, 14'h0033, 14'h0, 1);
      cmd("act_bank1",     1, 0, 0, 3'b000, 2'd1, 14'h0009, S_ACT, 0);
      desel("nop_c", 1, 14'h0);
      desel("nop_d", 1, 14'h0);
      desel("nop_e", 1, 14'h0);
      cmd("wra_bank1",     1, 0, 1, 3'b100, 2'd1, 14'h0403, S_WRA, 0);
      cmd("rd_after_wra",  1, 0, 1, 3'b101, 2'd1, 14'h0003, 14'h0, 1);
      cmd("ref_banks_open",1, 0, 1, 3'b001, 2'd0, 14'h0000, 14'h0, 1);
      cmd("mrw_banks_open",1, 0, 1, 3'b000, 2'd0, 14'h0011, 14'h0, 1);
      cmd("act_bank3",     1, 0, 0, 3'b000, 2'd3, 14'h0044, S_ACT, 0);
      cmd("pr_closed",     1, 0, 1, 3'b010, 2'd1, 14'h0000, S_PR, 0);
      cmd("pra",           1, 0, 1, 3'b010, 2'd0, 14'h0400, S_PRA, 0);
      cmd("ref_closed",    1, 0, 1, 3'b001, 2'd0, 14'h0000, S_REF, 0);
      cmd("mrw_closed",    1, 0, 1, 3'b000, 2'd2, 14'h0123, S_MRW, 0);
      cmd("sref_entry",    0, 0, 1, 3'b001, 2'd0, 14'h0000, S_SRF | S_CKEL, 0);
      cmd("rd_in_sref",    0, 0, 1, 3'b101, 2'd0, 14'h0007, 14'h0, 0);
      desel("sref_exit", 1, S_CKEH);
      cmd("act_bank2",     1, 0, 0, 3'b000, 2'd2, 14'h0021, S_ACT, 0);
      desel("nop_f", 1, 14'h0);
      desel("nop_g", 1, 14'h0);
      desel("nop_h", 1, 14'h0);
      cmd("pd_entry_nop",  0, 0, 1, 3'b111, 2'd0, 14'h0000, S_PD | S_CKEL, 0);
      cmd("rd_in_pd",      0, 0, 1, 3'b101, 2'd2, 14'h0005, 14'h0, 0);
      desel("pd_exit", 1, S_PDX | S_CKEH);
      cmd("rd_after_pd",   1, 0, 1, 3'b101, 2'd2, 14'h0005, S_RD, 0);
      cmd("pd_entry_rd",   0, 0, 1, 3'b101, 2'd2, 14'h0006, S_PD | S_CKEL, 1);
      desel("pd_exit2", 1, S_PDX | S_CKEH);
      cmd("rd_before_rst", 1, 0, 1, 3'b101, 2'd2, 14'h0009, S_RD, 0);
      @(posedge clk);
      #4;
      bus.cs_n = 1'b1;
      rst = 1'b1;
      x_bg = '0; x_ba = '0; x_row = '0; x_col = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cmd("rd_after_rst",  1, 0, 1, 3'b101, 2'd2, 14'h0009, 14'h0, 1);
      cmd("act_after_rst", 1, 0, 0, 3'b000, 2'd2, 14'h0077, S_ACT, 0);
      desel("nop_end", 1, 14'h0);
      repeat (3) @(negedge clk);
      done = 1'b1;
   end
endmodule
